// File: rtl/mux_pkg.sv
// Shared types for the arbitrated stream multiplexer.
package mux_pkg;

  typedef enum logic {
    ARB_FIXED,
    ARB_RR
  } arb_mode_e;

  typedef enum logic {
    UNLOCKED,
    LOCKED
  } lock_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority request picker; ptr=0 gives plain fixed priority.
module rr_arbiter #(
  parameter  int NUM_INPUTS = 4,
  localparam int SEL_WIDTH  = $clog2(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] req,
  input  logic [SEL_WIDTH-1:0]  ptr,
  output logic [NUM_INPUTS-1:0] gnt,
  output logic [SEL_WIDTH-1:0]  gnt_idx,
  output logic                  found
);

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= NUM_INPUTS) j = j - NUM_INPUTS;
      if (!found && req[j]) begin
        found   = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = SEL_WIDTH'(j);
      end
    end
  end

endmodule

// File: rtl/stream_arb_mux.sv
// N-way valid/ready mux with internal arbitration, packet lock
// and a registered output slice.
module stream_arb_mux
  import mux_pkg::*;
#(
  parameter  int        NUM_INPUTS = 4,
  parameter  int        WIDTH      = 32,
  parameter  arb_mode_e ARB_MODE   = ARB_RR,
  localparam int        SEL_WIDTH  = $clog2(NUM_INPUTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_INPUTS-1:0] in_valid,
  input  logic [WIDTH-1:0]      in_data [NUM_INPUTS],
  input  logic [NUM_INPUTS-1:0] in_last,
  output logic [NUM_INPUTS-1:0] in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_last,
  output logic [SEL_WIDTH-1:0]  out_sel,
  input  logic                  out_ready
);

  lock_state_e state, state_nxt;
  logic locked;
  logic [SEL_WIDTH-1:0] lock_sel;
  logic [SEL_WIDTH-1:0] rr_ptr;
  logic [SEL_WIDTH-1:0] arb_ptr;
  logic [SEL_WIDTH-1:0] arb_idx;
  logic [SEL_WIDTH-1:0] grant;
  logic [NUM_INPUTS-1:0] arb_gnt;
  logic arb_found;
  logic load_en;
  logic accept;
  logic acc_last;

  assign arb_ptr = (ARB_MODE == ARB_RR) ? rr_ptr : '0;

  rr_arbiter #(
    .NUM_INPUTS(NUM_INPUTS)
  ) u_arb (
    .req    (in_valid),
    .ptr    (arb_ptr),
    .gnt    (arb_gnt),
    .gnt_idx(arb_idx),
    .found  (arb_found)
  );

  // Reset also blocks intake so nothing is acknowledged while held.
  assign load_en  = !rst && (!out_valid || out_ready);
  assign grant    = locked ? lock_sel : arb_idx;
  assign acc_last = in_last[grant];
  assign accept   = load_en &&
                    (locked ? in_valid[lock_sel] : arb_found);

  always_comb begin
    in_ready = '0;
    if (load_en) begin
      if (locked) in_ready[lock_sel] = 1'b1;
      else        in_ready = arb_gnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= UNLOCKED;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      UNLOCKED: if (accept && !acc_last) state_nxt = LOCKED;
      LOCKED:   if (accept &&  acc_last) state_nxt = UNLOCKED;
      default:  state_nxt = UNLOCKED;
    endcase
  end

  always_comb begin
    locked = (state == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_sel <= '0;
      rr_ptr   <= '0;
    end else if (accept) begin
      if (!locked && !acc_last) lock_sel <= grant;
      if (acc_last) begin
        if (grant == SEL_WIDTH'(NUM_INPUTS - 1))
          rr_ptr <= '0;
        else
          rr_ptr <= grant + SEL_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data[grant];
      out_last  <= acc_last;
      out_sel   <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_arb_mux.sv
// Directed bench: round-robin and fixed-priority instances
// share one set of input drivers.
module tb_stream_arb_mux;
  import mux_pkg::*;

  localparam int N = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] in_valid;
  logic [N-1:0] in_last;
  logic [W-1:0] in_data [N];
  logic out_ready;

  logic [N-1:0] rr_ready, fx_ready;
  logic rr_valid, fx_valid;
  logic rr_last, fx_last;
  logic [W-1:0] rr_data, fx_data;
  logic [1:0] rr_sel, fx_sel;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  stream_arb_mux #(
    .NUM_INPUTS(N), .WIDTH(W), .ARB_MODE(ARB_RR)
  ) u_rr (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(rr_ready),
    .out_valid(rr_valid), .out_data(rr_data),
    .out_last(rr_last), .out_sel(rr_sel),
    .out_ready(out_ready)
  );

  stream_arb_mux #(
    .NUM_INPUTS(N), .WIDTH(W), .ARB_MODE(ARB_FIXED)
  ) u_fx (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(fx_ready),
    .out_valid(fx_valid), .out_data(fx_data),
    .out_last(fx_last), .out_sel(fx_sel),
    .out_ready(out_ready)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [W-1:0] base);
    for (int i = 0; i < N; i++) in_data[i] = base + W'(i);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    in_valid = '0;
    in_last = '1;
    out_ready = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = '1;
    in_last = '1;
    out_ready = 1'b1;
    set_data(32'h100);
    for (int c = 0; c < 3; c++) begin
      tick;
      nvec++;
      if (rr_ready !== 4'b0000 || fx_ready !== 4'b0000) begin
        nerr++;
        $display("FAIL rst_ready cyc%0d rr=%b fx=%b want 0000",
                 c, rr_ready, fx_ready);
      end
      nvec++;
      if (rr_valid !== 1'b0 || fx_valid !== 1'b0) begin
        nerr++;
        $display("FAIL rst_valid cyc%0d rr=%b fx=%b want 0",
                 c, rr_valid, fx_valid);
      end
      nvec++;
      if (rr_data !== 32'h0 || rr_sel !== 2'd0) begin
        nerr++;
        $display("FAIL rst_regs cyc%0d data=%h sel=%0d want 0/0",
                 c, rr_data, rr_sel);
      end
    end
  endtask

  task automatic test_rr_rotation;
    logic [1:0] exp;
    do_reset;
    set_data(32'h100);
    in_valid = '1;
    in_last = '1;
    #1;
    nvec++;
    if (rr_ready !== 4'b0001) begin
      nerr++;
      $display("FAIL rr_first_ready got %b want 0001", rr_ready);
    end
    for (int k = 0; k < 5; k++) begin
      tick;
      exp = 2'(k % 4);
      nvec++;
      if (rr_valid !== 1'b1 || rr_sel !== exp ||
          rr_data !== 32'h100 + 32'(exp)) begin
        nerr++;
        $display("FAIL rr_rot k%0d v=%b sel=%0d data=%h want 1/%0d/%h",
                 k, rr_valid, rr_sel, rr_data, exp,
                 32'h100 + 32'(exp));
      end
    end
  endtask

  task automatic test_fixed_priority;
    do_reset;
    set_data(32'h100);
    in_valid = 4'b1010;
    in_last = '1;
    for (int k = 0; k < 4; k++) begin
      #1;
      nvec++;
      if (fx_ready !== 4'b0010) begin
        nerr++;
        $display("FAIL fx_ready k%0d got %b want 0010", k, fx_ready);
      end
      tick;
      nvec++;
      if (fx_sel !== 2'd1 || fx_data !== 32'h101) begin
        nerr++;
        $display("FAIL fx_sel k%0d sel=%0d data=%h want 1/101",
                 k, fx_sel, fx_data);
      end
    end
    in_valid = 4'b1000;
    #1;
    nvec++;
    if (fx_ready !== 4'b1000) begin
      nerr++;
      $display("FAIL fx_ch3_ready got %b want 1000", fx_ready);
    end
    tick;
    nvec++;
    if (fx_sel !== 2'd3 || fx_data !== 32'h103) begin
      nerr++;
      $display("FAIL fx_ch3 sel=%0d data=%h want 3/103",
               fx_sel, fx_data);
    end
  endtask

  task automatic test_packet_lock;
    do_reset;
    set_data(32'h100);
    in_data[2] = 32'hA1;
    in_valid = 4'b0100;
    in_last = 4'b0001;
    tick;
    nvec++;
    if (rr_sel !== 2'd2 || rr_data !== 32'hA1 || rr_last !== 1'b0) begin
      nerr++;
      $display("FAIL lock_b1 sel=%0d data=%h last=%b want 2/a1/0",
               rr_sel, rr_data, rr_last);
    end
    in_valid = 4'b0101;
    in_data[2] = 32'hA2;
    #1;
    nvec++;
    if (rr_ready !== 4'b0100) begin
      nerr++;
      $display("FAIL lock_ready got %b want 0100", rr_ready);
    end
    tick;
    nvec++;
    if (rr_sel !== 2'd2 || rr_data !== 32'hA2) begin
      nerr++;
      $display("FAIL lock_b2 sel=%0d data=%h want 2/a2",
               rr_sel, rr_data);
    end
    in_valid = 4'b0001;
    #1;
    nvec++;
    if (rr_ready !== 4'b0100) begin
      nerr++;
      $display("FAIL lock_idle_ready got %b want 0100", rr_ready);
    end
    tick;
    nvec++;
    if (rr_valid !== 1'b0) begin
      nerr++;
      $display("FAIL lock_bubble valid=%b want 0", rr_valid);
    end
    in_valid = 4'b0101;
    in_data[2] = 32'hA3;
    in_last = 4'b0101;
    tick;
    nvec++;
    if (rr_sel !== 2'd2 || rr_data !== 32'hA3 || rr_last !== 1'b1) begin
      nerr++;
      $display("FAIL lock_b3 sel=%0d data=%h last=%b want 2/a3/1",
               rr_sel, rr_data, rr_last);
    end
    in_valid = 4'b0001;
    tick;
    nvec++;
    if (rr_valid !== 1'b1 || rr_sel !== 2'd0 || rr_data !== 32'h100) begin
      nerr++;
      $display("FAIL lock_release v=%b sel=%0d data=%h want 1/0/100",
               rr_valid, rr_sel, rr_data);
    end
  endtask

  task automatic test_backpressure;
    do_reset;
    set_data(32'h0);
    in_data[1] = 32'hDEADBEEF;
    in_valid = 4'b0010;
    in_last = '1;
    tick;
    nvec++;
    if (rr_sel !== 2'd1 || rr_data !== 32'hDEADBEEF) begin
      nerr++;
      $display("FAIL bp_load sel=%0d data=%h want 1/deadbeef",
               rr_sel, rr_data);
    end
    out_ready = 1'b0;
    in_data[1] = 32'h12345678;
    for (int c = 0; c < 5; c++) begin
      #1;
      nvec++;
      if (rr_ready !== 4'b0000) begin
        nerr++;
        $display("FAIL bp_ready c%0d got %b want 0000", c, rr_ready);
      end
      tick;
      nvec++;
      if (rr_valid !== 1'b1 || rr_data !== 32'hDEADBEEF) begin
        nerr++;
        $display("FAIL bp_hold c%0d v=%b data=%h want 1/deadbeef",
                 c, rr_valid, rr_data);
      end
    end
    out_ready = 1'b1;
    #1;
    nvec++;
    if (rr_ready !== 4'b0010) begin
      nerr++;
      $display("FAIL bp_release_ready got %b want 0010", rr_ready);
    end
    tick;
    nvec++;
    if (rr_valid !== 1'b1 || rr_data !== 32'h12345678) begin
      nerr++;
      $display("FAIL bp_next v=%b data=%h want 1/12345678",
               rr_valid, rr_data);
    end
  endtask

  task automatic test_reset_midpkt;
    do_reset;
    set_data(32'h300);
    in_valid = 4'b0010;
    in_last = '1;
    tick;
    in_valid = 4'b1000;
    in_last = 4'b0000;
    in_data[3] = 32'h33;
    tick;
    nvec++;
    if (rr_sel !== 2'd3 || rr_last !== 1'b0) begin
      nerr++;
      $display("FAIL mid_b1 sel=%0d last=%b want 3/0", rr_sel, rr_last);
    end
    rst = 1'b1;
    in_valid = '1;
    tick;
    nvec++;
    if (rr_valid !== 1'b0) begin
      nerr++;
      $display("FAIL mid_rst valid=%b want 0", rr_valid);
    end
    rst = 1'b0;
    in_last = '1;
    #1;
    nvec++;
    if (rr_ready !== 4'b0001) begin
      nerr++;
      $display("FAIL mid_ready got %b want 0001", rr_ready);
    end
    tick;
    nvec++;
    if (rr_sel !== 2'd0 || rr_data !== 32'h300) begin
      nerr++;
      $display("FAIL mid_next sel=%0d data=%h want 0/300",
               rr_sel, rr_data);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = '0;
    in_last = '1;
    out_ready = 1'b1;
    set_data(32'h0);
    test_reset;
    test_rr_rotation;
    test_fixed_priority;
    test_packet_lock;
    test_backpressure;
    test_reset_midpkt;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
